// File: rtl/pe_instr_issuer.sv
// West-edge instruction issuer for one systolic-array row: buffers host entries in a FIFO and
// issues instruction / advance transfers into the first PE under per-column credit control.
module pe_instr_issuer #(
    parameter int unsigned NUM_COLS     = 4,
    parameter int unsigned INSTR_BIT    = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PE_BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_BIT-1:0] host_instr,
    input  logic [NUM_COLS-1:0]  host_col_mask,
    input  logic                 host_is_change,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic                 flush,
    output logic [INSTR_BIT-1:0] instr_w,
    output logic [NUM_COLS-1:0]  instr_w_valid,
    input  logic                 instr_w_ready,
    output logic                 change_w_instr,
    output logic [NUM_COLS-1:0]  change_instr_w_valid,
    input  logic                 change_instr_w_ready,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 1 + NUM_COLS + INSTR_BIT;
    localparam logic [1:0] CreditMax = 2'(PE_BUF_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StSendI = 2'd2;
    localparam logic [1:0] StSendC = 2'd3;

    logic [EW-1:0]                fifo_q [FIFO_DEPTH];
    logic [AW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]                   state_q, state_d;
    logic [NUM_COLS-1:0][1:0]     credit_q, credit_d;
    logic [INSTR_BIT-1:0]         instr_q, instr_d;
    logic [NUM_COLS-1:0]          ivalid_q, ivalid_d;
    logic [NUM_COLS-1:0]          cvalid_q, cvalid_d;
    logic                         chg_q, chg_d;
    logic [7:0]                   drop_q, drop_d;

    logic                         empty, full, push, pop, credit_ok;
    logic [EW-1:0]                head;
    logic                         head_change;
    logic [NUM_COLS-1:0]          head_mask;
    logic [INSTR_BIT-1:0]         head_instr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Flush wins over a same-cycle push even though host_ready is high.
    assign push  = host_valid && !full && !flush;

    assign head        = fifo_q[rd_ptr_q[AW-1:0]];
    assign head_change = head[EW-1];
    assign head_mask   = head[INSTR_BIT +: NUM_COLS];
    assign head_instr  = head[INSTR_BIT-1:0];

    always_comb begin
        credit_ok = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (head_mask[c] && (credit_q[c] == 2'd0)) begin
                credit_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        cvalid_d = cvalid_q;
        chg_d    = chg_q;
        drop_d   = drop_q;
        pop      = 1'b0;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (empty) begin
                    state_d = StIdle;
                end else if (head_mask == '0) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end else if (head_change) begin
                    pop      = 1'b1;
                    chg_d    = 1'b1;
                    cvalid_d = head_mask;
                    state_d  = StSendC;
                end else if (credit_ok) begin
                    pop      = 1'b1;
                    instr_d  = head_instr;
                    ivalid_d = head_mask;
                    state_d  = StSendI;
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (head_mask[c]) begin
                            credit_d[c] = credit_q[c] - 2'd1;
                        end
                    end
                end
            end
            StSendI: begin
                if (instr_w_ready) begin
                    ivalid_d = '0;
                    state_d  = empty ? StIdle : StFetch;
                end
            end
            StSendC: begin
                if (change_instr_w_ready) begin
                    cvalid_d = '0;
                    chg_d    = 1'b0;
                    state_d  = empty ? StIdle : StFetch;
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (cvalid_q[c] && (credit_q[c] < CreditMax)) begin
                            credit_d[c] = credit_q[c] + 2'd1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = StIdle;
            ivalid_d = '0;
            cvalid_d = '0;
            chg_d    = 1'b0;
            drop_d   = drop_q;
            for (int c = 0; c < NUM_COLS; c++) begin
                credit_d[c] = CreditMax;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {host_is_change, host_col_mask, host_instr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= StIdle;
            instr_q  <= '0;
            ivalid_q <= '0;
            cvalid_q <= '0;
            chg_q    <= 1'b0;
            drop_q   <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                credit_q[c] <= CreditMax;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            cvalid_q <= cvalid_d;
            chg_q    <= chg_d;
            drop_q   <= drop_d;
            credit_q <= credit_d;
        end
    end

    assign host_ready           = !full;
    assign instr_w              = instr_q;
    assign instr_w_valid        = ivalid_q;
    assign change_w_instr       = chg_q;
    assign change_instr_w_valid = cvalid_q;
    assign busy                 = !empty || (state_q != StIdle);
    assign drop_count           = drop_q;

endmodule
